// File: rtl/uart_inst_rx.sv
// uart_inst_rx: UART receiver on the board RsRx line. It turns host bytes
// into calculator instruction words on inst_wd/inst_vld, which is the same
// path the button debouncer drives.
// The default frame is 8N1, LSB first, with 2-flop input synchronisation.
// Optional feature: define UART_PARITY_EN to receive 8E1 frames. That build
// adds a parity_err output pulse for frames whose even parity does not match.
module uart_inst_rx #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] inst_wd,
  output logic       inst_vld,
  output logic       frame_err,
`ifdef UART_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  // Mid-bit sampling needs enough clocks per bit to stay centred.
  if (CLKS_PER_BIT < 16) begin : g_bad_baud
    $error("uart_inst_rx: CLK_HZ/BAUD must be >= 16");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       wd_q, wd_d;
  logic             vld_q, vld_d;
  logic             ferr_q, ferr_d;
  logic             rx_meta_q, rx_s_q;
  logic             baud_tick;
`ifdef UART_PARITY_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;
`endif

  assign baud_tick = (baud_q == '0);

  // Two-flop synchroniser for the asynchronous serial line.
  // NOTE: these flops reset to 1, not 0. A 0 would look like a start bit as soon as reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State, counters, data and output pulse registers.
  // NOTE: sequential state uses non-blocking assignments only, so every flop updates from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wd_q    <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      wd_q    <= wd_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state logic: frame sequencing, mid-bit sampling and pulse generation.
  // NOTE: every signal gets a default first, so no path through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    wd_d    = wd_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          baud_d  = CNT_W'(HALF_BIT - 1);
        end
      end

      S_START: begin
        if (baud_tick) begin
          if (!rx_s_q) begin
            state_d = S_DATA;
            baud_d  = CNT_W'(CLKS_PER_BIT - 1);
            bit_d   = '0;
          end else begin
            // The line went high again before mid-bit, so this was a glitch and not a start bit.
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          baud_d  = CNT_W'(CLKS_PER_BIT - 1);
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
      end

      S_PARITY: begin
`ifdef UART_PARITY_EN
        if (baud_tick) begin
          par_d   = rx_s_q;
          baud_d  = CNT_W'(CLKS_PER_BIT - 1);
          state_d = S_STOP;
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
`else
        state_d = S_IDLE;
`endif
      end

      S_STOP: begin
        if (baud_tick) begin
          // Returning to IDLE on the sample cycle lets a back-to-back start bit be seen on the next clock.
          state_d = S_IDLE;
          if (!rx_s_q) begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
`ifdef UART_PARITY_EN
          end else if (^{shift_q, par_q}) begin
            perr_d = 1'b1;
`endif
          end else begin
            wd_d  = shift_q;
            vld_d = 1'b1;
          end
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
      end

      S_BREAK: begin
        // Wait here while the line is held low, so a break is not read as a run of 0x00 bytes.
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign inst_wd   = wd_q;
  assign inst_vld  = vld_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);
`ifdef UART_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_inst_rx.sv
// tb_uart_inst_rx: self-checking bench for uart_inst_rx at 100 MHz / 1 Mbaud.
// A serial line model drives the frames. A queue of the bytes expected from
// well-formed frames is compared with the inst_vld pulses captured by a monitor.
module tb_uart_inst_rx;

  localparam int  CPB    = 100;
  localparam time BIT_NS = 1000;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Expected delay from the start falling edge to inst_vld: middle of the stop bit plus sync/register delay.
  localparam int EXP_LAT = FRAME_BITS * CPB - CPB / 2 + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] inst_wd;
  logic       inst_vld;
  logic       frame_err;
  logic       busy;
`ifdef UART_PARITY_EN
  logic       parity_err;
  logic       flip_par = 1'b0;
  int         pe_cnt   = 0;
`endif

  uart_inst_rx #(.CLK_HZ(100_000_000), .BAUD(1_000_000)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .inst_wd   (inst_wd),
    .inst_vld  (inst_vld),
    .frame_err (frame_err),
`ifdef UART_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every output pulse and the cross-signal rules.
  logic [7:0] got_q[$];
  int         pulse_cyc[$];
  int         fe_cnt = 0;
  int         overlap_cnt = 0;
  int         busy_pulse_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (inst_vld) begin
        got_q.push_back(inst_wd);
        pulse_cyc.push_back(cyc);
        if (busy) busy_pulse_cnt++;
      end
      if (frame_err) fe_cnt++;
      if (inst_vld && frame_err) overlap_cnt++;
`ifdef UART_PARITY_EN
      if (parity_err) pe_cnt++;
      if (parity_err && (inst_vld || frame_err)) overlap_cnt++;
`endif
    end
  end

  // Reference model: the bytes that well-formed frames must deliver, and the value inst_wd must hold.
  logic [7:0] exp_q[$];
  logic [7:0] exp_wd = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) check(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  // Drive one frame (start bit, data LSB first, optional parity bit, stop bit). After a low stop bit the line stays low.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    start_cyc = cyc;
    rx = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #BIT_NS;
    end
`ifdef UART_PARITY_EN
    rx = (^b) ^ flip_par;
    #BIT_NS;
`endif
    rx = stop_bit;
    #BIT_NS;
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_q.push_back(b);
    exp_wd = b;
    send_frame(b, 1'b1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int fe0;
    int t0;
    logic [7:0] b;

    // Values while reset is held at start-up.
    #95;
    check("rst_wd",   inst_wd,   8'h00);
    check("rst_vld",  inst_vld,  1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy,      1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Single byte 0x25 (PUSH r2,5): one pulse at the expected latency.
    pulse_cyc.delete();
    send_good(8'h25);
    repeat (20) @(negedge clk);
    lat = (pulse_cyc.size() > 0) ? pulse_cyc[0] - start_cyc : -1;
    check("single_lat_ok", (lat >= EXP_LAT - 5) && (lat <= EXP_LAT + 5), 1'b1);
    check("single_wd", inst_wd, exp_wd);
    check_rx("single");
    check("single_ferr", fe_cnt, 0);

    // Reset while the line is idle clears the held word.
    rst = 1'b1;
    #1000;
    check("idle_rst_wd",   inst_wd,  8'h00);
    check("idle_rst_vld",  inst_vld, 1'b0);
    check("idle_rst_busy", busy,     1'b0);
    exp_wd = 8'h00;
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Back-to-back frames with no idle gap between them.
    pulse_cyc.delete();
    send_good(8'h25);
    send_good(8'h13);
    send_good(8'h69);
    send_good(8'hE0);
    repeat (20) @(negedge clk);
    check("b2b_pulses", pulse_cyc.size(), 4);
    for (int i = 1; i < pulse_cyc.size(); i++)
      check("b2b_spacing", pulse_cyc[i] - pulse_cyc[i-1], FRAME_BITS * CPB);
    check("b2b_wd", inst_wd, exp_wd);
    check_rx("b2b");

    // Random bytes with random idle gaps between frames.
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      send_good(b);
      repeat ($urandom_range(0, 300)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("rand_wd", inst_wd, exp_wd);
    check_rx("rand");

    // 300 ns low glitch on the idle line.
    fe0 = fe_cnt;
    @(negedge clk);
    t0 = cyc;
    rx = 1'b0;
    #300;
    rx = 1'b1;
    while (busy && (cyc - t0) < 60) @(negedge clk);
    check("glitch_busy_clear", busy, 1'b0);
    repeat (20) @(negedge clk);
    check("glitch_ferr", fe_cnt, fe0);
    check_rx("glitch");

    // Bad stop bit, then the line is held low for three more bit times.
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b0);
    #(3 * BIT_NS);
    check("break_busy_held", busy, 1'b1);
    check("break_ferr_once", fe_cnt, fe0 + 1);
    rx = 1'b1;
    t0 = cyc;
    while (busy && (cyc - t0) < 20) @(negedge clk);
    check("break_busy_clear", busy, 1'b0);
    check("break_wd_kept", inst_wd, exp_wd);
    check_rx("break");

`ifdef UART_PARITY_EN
    // Even parity: a correct parity bit delivers the byte; a flipped one gives only parity_err.
    t0 = pe_cnt;
    send_good(8'h25);
    repeat (20) @(negedge clk);
    check("par_ok_perr", pe_cnt, t0);
    check_rx("par_ok");
    flip_par = 1'b1;
    send_frame(8'h25, 1'b1);
    flip_par = 1'b0;
    repeat (20) @(negedge clk);
    check("par_bad_perr", pe_cnt, t0 + 1);
    check_rx("par_bad");
`endif

    // Reset in the middle of a frame: no pulse, then a clean byte is received.
    @(negedge clk);
    rx = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 4; i++) begin
      rx = 1'($urandom);
      #BIT_NS;
    end
    rst = 1'b1;
    rx  = 1'b1;
    #1000;
    check("mid_rst_wd",   inst_wd,  8'h00);
    check("mid_rst_vld",  inst_vld, 1'b0);
    check("mid_rst_busy", busy,     1'b0);
    exp_wd = 8'h00;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_rx("mid_rst_nopulse");
    b = 8'($urandom);
    send_good(b);
    repeat (20) @(negedge clk);
    check("mid_rst_wd_after", inst_wd, exp_wd);
    check_rx("mid_rst_after");

    // Rules that apply across the whole run.
    check("overlap_pulses", overlap_cnt, 0);
    check("busy_in_pulse", busy_pulse_cnt, 0);
    check("total_ferr", fe_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
